inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
Boot-time program writer for the instruction memory. It receives a byte stream over a valid/ready handshake and packs the bytes into instruction words. Each word is written through the write port (A/W/D) of mem_instruction, the port that fetch_instruction only reads. When the programmed word count has been written, it asserts run_o, which releases the core (fetch/decode/execute) from reset.

Parameters:
WORD, 32, instruction word width; must be a multiple of 8
ADDR, 16, instruction memory address width
BASE, 0, first address written
TIMEOUT, 1024, maximum idle cycles between bytes inside a transfer

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
rx_valid_i  in  1  byte on rx_data_i is valid
rx_data_i  in  8  stream byte
rx_ready_o  out  1  loader accepts a byte this cycle
mem_a_o  out  ADDR  instruction memory write address
mem_w_o  out  1  instruction memory write strobe
mem_d_o  out  WORD  instruction memory write data
run_o  out  1  program loaded; core may run (active-high)
busy_o  out  1  transfer in progress
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, every output 0, address=BASE, byte and word counters 0, timeout counter 0.
- A byte is accepted only on a rising edge where rx_valid_i & rx_ready_o.
- rx_ready_o=1 in IDLE, HDR_LO and DATA. It is 0 in WRITE and DONE.
- Stream format: 2-byte word count N, most significant byte first. Then N words, each sent as WORD/8 bytes, most significant byte first.
- IDLE: accepting a byte latches count[15:8], clears err_o, sets busy_o=1 and moves to HDR_LO.
- HDR_LO: accepting a byte latches count[7:0]. If the full count is 0, go to DONE; otherwise go to DATA.
- DATA: each accepted byte shifts into the word register (shift left by 8, new byte into the low 8 bits). On the (WORD/8)th byte, go to WRITE; the byte counter wraps to 0.
- WRITE: exactly one cycle with mem_w_o=1, mem_a_o=current address, mem_d_o=assembled word. On that edge the address increments and the remaining count decrements.
  - If remaining count becomes 0, go to DONE.
  - Otherwise return to DATA.
  - Latency: the write strobe occurs in the cycle after the last byte of the word is accepted.
- Address arithmetic is modulo 2^ADDR: a count exceeding memory depth wraps and overwrites from address 0.
- mem_a_o and mem_d_o hold their last values when mem_w_o=0. They are only meaningful while mem_w_o=1. The integrator muxes the memory A port by run_o: loader address while run_o=0, fetch address while run_o=1.
- DONE: run_o=1, busy_o=0, rx_ready_o=0. DONE persists until reset; further stream bytes are not accepted.
- Timeout: in HDR_LO or DATA, the timeout counter increments each cycle without an accepted byte and clears when a byte is accepted. When it reaches TIMEOUT:
  - set err_o=1, busy_o=0;
  - return to IDLE with address=BASE and counters cleared;
  - memory already written is not rolled back.
- Reset asserted mid-transfer aborts immediately to the reset state, including from WRITE: no write strobe occurs after reset falls.
- A byte presented while rx_ready_o=0 is not consumed. The sender must hold it stable until accepted.

Test Plan:
- Stream 00 02 | 12 34 56 78 | 9A BC DE F0 with continuous valid. Required: mem_w_o pulses twice, writing (A=0, D=12345678) and then (A=1, D=9ABCDEF0). run_o rises the cycle after the second write. rx_ready_o=0 during each WRITE cycle.
- Stream 00 00. Required: no mem_w_o pulse, run_o=1 two cycles after the first byte is accepted, busy_o=0.
- Same two-word stream with rx_valid_i toggling every other cycle. Required: identical memory contents and writes, no byte lost or duplicated.
- TIMEOUT=8; send 00 01 12 34, then idle. Required: err_o=1 eight cycles after the byte 34 is accepted, state IDLE, run_o=0, no write. Then send 00 01 AA BB CC DD. Required: err_o clears on the first byte, write (A=0, D=AABBCCDD), run_o=1.
- Drive reset=0 in the cycle after the 4th data byte is accepted. Required: mem_w_o stays 0 and all outputs read 0 immediately. After release, a new stream writes starting at BASE.
- ADDR=2; stream count 5 with data 1..5. Required: addresses 0,1,2,3,0 are written, final mem[0]=5, run_o=1.

Source files
------------

// File: rtl/inst_loader.sv
// Boot-time instruction memory writer: unpacks a length-prefixed byte stream into
// instruction words, writes them sequentially, then releases the core via run_o.
module inst_loader #(
  parameter int WORD    = 32,
  parameter int ADDR    = 16,
  parameter int BASE    = 0,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_valid_i,
  input  logic [7:0]      rx_data_i,
  output logic            rx_ready_o,
  output logic [ADDR-1:0] mem_a_o,
  output logic            mem_w_o,
  output logic [WORD-1:0] mem_d_o,
  output logic            run_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int BPW = WORD / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [15:0]     remain_q;
  logic [BCW-1:0]  byte_q;
  logic [WORD-1:0] word_q;
  logic [ADDR-1:0] addr_q;
  logic [TCW-1:0]  tmo_q;

  logic            ready_q;
  logic            mem_w_q;
  logic [ADDR-1:0] mem_a_q;
  logic [WORD-1:0] mem_d_q;
  logic            run_q;
  logic            busy_q;
  logic            err_q;

  logic            accept;
  logic            last_byte;
  logic            tmo_hit;
  logic [15:0]     count_d;
  logic [15:0]     remain_d;
  logic [WORD-1:0] word_d;

  assign accept    = rx_valid_i & ready_q;
  assign last_byte = (byte_q == BCW'(BPW - 1));
  assign tmo_hit   = (tmo_q == TCW'(TIMEOUT - 1));
  assign count_d   = {remain_q[15:8], rx_data_i};
  assign remain_d  = remain_q - 16'd1;

  // Most significant byte arrives first, so each new byte enters at the bottom.
  generate
    if (WORD == 8) begin : g_word8
      assign word_d = rx_data_i;
    end else begin : g_wordn
      assign word_d = {word_q[WORD-9:0], rx_data_i};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      byte_q   <= '0;
      word_q   <= '0;
      addr_q   <= ADDR'(BASE);
      tmo_q    <= '0;
      ready_q  <= 1'b0;
      mem_w_q  <= 1'b0;
      mem_a_q  <= '0;
      mem_d_q  <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mem_w_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            remain_q <= {rx_data_i, 8'h00};
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            tmo_q    <= '0;
            state_q  <= S_HDR_LO;
          end
        end

        S_HDR_LO, S_DATA: begin
          if (accept) begin
            tmo_q <= '0;
            if (state_q == S_HDR_LO) begin
              remain_q <= count_d;
              if (count_d == 16'd0) begin
                state_q <= S_DONE;
                run_q   <= 1'b1;
                busy_q  <= 1'b0;
                ready_q <= 1'b0;
              end else begin
                state_q <= S_DATA;
              end
            end else begin
              word_q <= word_d;
              if (last_byte) begin
                byte_q  <= '0;
                ready_q <= 1'b0;
                mem_w_q <= 1'b1;
                mem_a_q <= addr_q;
                mem_d_q <= word_d;
                state_q <= S_WRITE;
              end else begin
                byte_q <= byte_q + 1'b1;
              end
            end
          end else if (tmo_hit) begin
            // Abandon the transfer; words already written stay in memory.
            state_q  <= S_IDLE;
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            addr_q   <= ADDR'(BASE);
            remain_q <= '0;
            byte_q   <= '0;
            tmo_q    <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_WRITE: begin
          addr_q   <= addr_q + 1'b1;
          remain_q <= remain_d;
          if (remain_d == 16'd0) begin
            state_q <= S_DONE;
            run_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_DATA;
            ready_q <= 1'b1;
          end
        end

        S_DONE: begin
          ready_q <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_ready_o = ready_q;
  assign mem_w_o    = mem_w_q;
  assign mem_a_o    = mem_a_q;
  assign mem_d_o    = mem_d_q;
  assign run_o      = run_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a stream-index model predicts every output each
// cycle, and literal end-of-test expectations pin the model itself.
module tb_inst_loader;

  localparam int WORD    = 32;
  localparam int ADDR    = 2;
  localparam int BASE    = 0;
  localparam int TIMEOUT = 8;
  localparam int BPW     = WORD / 8;
  localparam int DEPTH   = 1 << ADDR;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            rx_valid_i = 1'b0;
  logic [7:0]      rx_data_i = 8'h00;
  logic            rx_ready_o;
  logic [ADDR-1:0] mem_a_o;
  logic            mem_w_o;
  logic [WORD-1:0] mem_d_o;
  logic            run_o;
  logic            busy_o;
  logic            err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inst_loader #(
    .WORD(WORD), .ADDR(ADDR), .BASE(BASE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .mem_a_o(mem_a_o), .mem_w_o(mem_w_o), .mem_d_o(mem_d_o),
    .run_o(run_o), .busy_o(busy_o), .err_o(err_o)
  );

  // Model: expected outputs for the current cycle plus stream position.
  bit          e_ready = 0, e_busy = 0, e_run = 0, e_err = 0, e_w = 0;
  int          e_a = 0;
  logic [31:0] e_d = '0;
  int          idx = 0, idle = 0, n_words = 0;
  bit          done = 0;
  logic [7:0]  b [0:63];

  logic [WORD-1:0] shadow [0:DEPTH-1];
  int              wr_count = 0;
  logic [7:0]      stream [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gap);
    int waited;
    bit acc;
    waited = 0;
    acc = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i  = v;
    while (!acc && waited < 40) begin
      @(negedge clk);
      acc = rx_ready_o;
      @(posedge clk);
      #1;
      waited++;
    end
    check($sformatf("accept_%02h", v), {31'd0, acc}, 32'd1);
    rx_valid_i = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_stream(input bit gap);
    foreach (stream[i]) send_byte(stream[i], gap);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int w0;
    fork
      forever begin
        bit acc, nxt_w;
        @(negedge clk);
        if (!reset) begin
          e_ready = 0; e_busy = 0; e_run = 0; e_err = 0; e_w = 0; e_a = 0; e_d = '0;
          idx = 0; idle = 0; n_words = 0; done = 0;
        end
        check("ready", {31'd0, rx_ready_o}, {31'd0, e_ready});
        check("busy",  {31'd0, busy_o},     {31'd0, e_busy});
        check("run",   {31'd0, run_o},      {31'd0, e_run});
        check("err",   {31'd0, err_o},      {31'd0, e_err});
        check("mem_w", {31'd0, mem_w_o},    {31'd0, e_w});
        if (mem_w_o && e_w) begin
          check("mem_a", 32'(mem_a_o), 32'(e_a));
          check("mem_d", mem_d_o, e_d);
        end
        if (mem_w_o) begin
          shadow[mem_a_o] = mem_d_o;
          wr_count++;
        end
        if (reset) begin
          acc   = rx_valid_i && e_ready;
          nxt_w = 1'b0;
          if (e_w) begin
            if ((idx - 2) / BPW == n_words) done = 1;
          end else if (!done && acc) begin
            b[idx] = rx_data_i;
            idx++;
            idle = 0;
            if (idx == 1) begin
              e_err = 0;
            end else if (idx == 2) begin
              n_words = {b[0], b[1]};
              if (n_words == 0) done = 1;
            end else if ((idx - 2) % BPW == 0) begin
              nxt_w = 1'b1;
              e_a   = (BASE + (idx - 2) / BPW - 1) % DEPTH;
              e_d   = '0;
              for (int j = 0; j < BPW; j++) e_d = {e_d[23:0], b[idx - BPW + j]};
            end
          end else if (!done && idx > 0) begin
            idle++;
            if (idle == TIMEOUT) begin
              e_err = 1;
              idx   = 0;
              idle  = 0;
            end
          end
          e_w     = nxt_w;
          e_run   = done;
          e_busy  = (idx > 0) && !done;
          e_ready = !done && !nxt_w;
        end
      end
    join_none

    // Two words, continuous valid.
    do_reset();
    w0 = wr_count;
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_stream(1'b0);
    settle(3);
    check("t1_writes", 32'(wr_count - w0), 32'd2);
    check("t1_mem0", shadow[0], 32'h12345678);
    check("t1_mem1", shadow[1], 32'h9ABCDEF0);
    check("t1_run", {31'd0, run_o}, 32'd1);
    check("t1_busy", {31'd0, busy_o}, 32'd0);

    // Zero-length program.
    do_reset();
    w0 = wr_count;
    stream = '{8'h00, 8'h00};
    send_stream(1'b0);
    check("t2_run", {31'd0, run_o}, 32'd1);
    check("t2_busy", {31'd0, busy_o}, 32'd0);
    settle(3);
    check("t2_writes", 32'(wr_count - w0), 32'd0);

    // Two words with valid dropping every other cycle.
    do_reset();
    shadow[0] = '0;
    shadow[1] = '0;
    w0 = wr_count;
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_stream(1'b1);
    settle(3);
    check("t3_writes", 32'(wr_count - w0), 32'd2);
    check("t3_mem0", shadow[0], 32'h12345678);
    check("t3_mem1", shadow[1], 32'h9ABCDEF0);
    check("t3_run", {31'd0, run_o}, 32'd1);

    // Timeout mid-word, then a clean retry.
    do_reset();
    w0 = wr_count;
    stream = '{8'h00, 8'h01, 8'h12, 8'h34};
    send_stream(1'b0);
    settle(7);
    check("t4_err_early", {31'd0, err_o}, 32'd0);
    settle(1);
    check("t4_err", {31'd0, err_o}, 32'd1);
    check("t4_busy", {31'd0, busy_o}, 32'd0);
    check("t4_run", {31'd0, run_o}, 32'd0);
    check("t4_ready", {31'd0, rx_ready_o}, 32'd1);
    check("t4_nowrite", 32'(wr_count - w0), 32'd0);
    send_byte(8'h00, 1'b0);
    check("t4_err_clr", {31'd0, err_o}, 32'd0);
    stream = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(1'b0);
    settle(3);
    check("t4_writes", 32'(wr_count - w0), 32'd1);
    check("t4_mem0", shadow[0], 32'hAABBCCDD);
    check("t4_run2", {31'd0, run_o}, 32'd1);

    // Reset lands on the would-be write cycle.
    do_reset();
    w0 = wr_count;
    stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stream(1'b0);
    reset = 1'b0;
    #1;
    check("t5_mem_w", {31'd0, mem_w_o}, 32'd0);
    check("t5_ready", {31'd0, rx_ready_o}, 32'd0);
    check("t5_busy", {31'd0, busy_o}, 32'd0);
    check("t5_mem_a", 32'(mem_a_o), 32'd0);
    check("t5_mem_d", mem_d_o, 32'd0);
    settle(2);
    reset = 1'b1;
    check("t5_nowrite", 32'(wr_count - w0), 32'd0);
    stream = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_stream(1'b0);
    settle(3);
    check("t5_writes", 32'(wr_count - w0), 32'd1);
    check("t5_mem0", shadow[0], 32'hCAFEBABE);
    check("t5_run", {31'd0, run_o}, 32'd1);

    // Five words into a four-entry memory wraps to address 0.
    do_reset();
    w0 = wr_count;
    stream = '{8'h00, 8'h05};
    for (int k = 1; k <= 5; k++) begin
      stream.push_back(8'h00);
      stream.push_back(8'h00);
      stream.push_back(8'h00);
      stream.push_back(8'(k));
    end
    send_stream(1'b0);
    settle(3);
    check("t6_writes", 32'(wr_count - w0), 32'd5);
    check("t6_mem0", shadow[0], 32'd5);
    check("t6_mem1", shadow[1], 32'd2);
    check("t6_mem2", shadow[2], 32'd3);
    check("t6_mem3", shadow[3], 32'd4);
    check("t6_run", {31'd0, run_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
